// File: rtl/serial_fulladd_if.sv
// Purpose: operand/result bundle for the bit-serial adder (start/done handshake).
// Latency: none, wires only.
// Backpressure: none; start is only honoured while the adder is not busy.
//
// Signals:
//   start  master->slave  request a new addition
//   a, b   master->slave  WIDTH-bit operands
//   cin    master->slave  carry-in
//   busy   slave->master  bits are being processed
//   done   slave->master  one-cycle pulse, sum/cout just became valid
//   sum    slave->master  WIDTH-bit registered result
//   cout   slave->master  registered carry-out
interface serial_fulladd_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_fulladd.sv
// Purpose: bit-serial WIDTH-bit adder, one full-adder cell plus registered carry, LSB first.
// Latency: start accepted at edge k -> sum/cout valid and done pulsed after edge k+WIDTH.
// Backpressure: start ignored while busy; a start in the done cycle is accepted back-to-back.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  serial_fulladd_if.slave: start/a/b/cin in, busy/done/sum/cout out
module serial_fulladd #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_fulladd_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             step;
  logic             last;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             s_bit;
  logic             c_bit;

  // Single full-adder cell working on the current LSBs.
  assign s_bit = a_sh[0] ^ b_sh[0] ^ carry;
  assign c_bit = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

  // Sum bits enter at the MSB end so after WIDTH shifts bit 0 sits at the LSB.
  assign res_nxt = {s_bit, res_sh[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Accepting here keeps throughput at one result per WIDTH+1 cycles.
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (load) begin
      a_sh  <= bus.a;
      b_sh  <= bus.b;
      carry <= bus.cin;
      cnt   <= '0;
    end else if (step) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= c_bit;
      res_sh <= res_nxt;
      cnt    <= cnt + CW'(1);
      // Visible result only moves on the RUN->DONE edge; it holds otherwise.
      if (last) begin
        sum_q  <= res_nxt;
        cout_q <= c_bit;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_fulladd.sv
// Purpose: self-checking bench for serial_fulladd with a cycle model and result scoreboard.
// Latency: model expects done exactly WIDTH edges after each accepted start.
// Backpressure: model ignores start while its own run counter is non-zero.
module tb_serial_fulladd;

  localparam int W = 8;

  logic clk;
  logic rst;

  serial_fulladd_if #(.WIDTH(W)) bus ();

  serial_fulladd #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, advanced once per cycle from the negedge monitor.
  int         m_rem  = 0;
  bit         m_done = 1'b0;
  logic [W:0] m_held = '0;
  logic [W:0] q[$];

  always @(negedge clk) begin
    if (rst) begin
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_result", {23'd0, bus.cout, bus.sum}, 32'd0);
      m_rem  = 0;
      m_done = 1'b0;
      m_held = '0;
      q.delete();
    end else begin
      check("busy", {31'd0, bus.busy}, {31'd0, (m_rem > 0)});
      check("done", {31'd0, bus.done}, {31'd0, m_done});
      if (m_done) begin
        if (q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          m_held = q.pop_front();
        end
      end
      check("result", {23'd0, bus.cout, bus.sum}, {23'd0, m_held});
      // Advance the model to what the DUT should show after the coming edge.
      if (m_rem > 0) begin
        m_rem--;
        m_done = (m_rem == 0);
      end else begin
        m_done = 1'b0;
        if (bus.start) begin
          q.push_back({1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin});
          m_rem = W;
        end
      end
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
    bus.start = s;
  endtask

  // One-cycle start pulse, then wait long enough for the done cycle to pass.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(posedge clk); #1 drive(a, b, c, 1'b1);
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (W + 2) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_sum", {24'd0, bus.sum}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);

    // Basic and boundary sums.
    do_op(8'h35, 8'h4A, 1'b0);
    check("op_35_4a", {23'd0, bus.cout, bus.sum}, 32'h07F);
    do_op(8'hFF, 8'h01, 1'b0);
    check("op_ff_01", {23'd0, bus.cout, bus.sum}, 32'h100);
    do_op(8'hFF, 8'hFF, 1'b1);
    check("op_ff_ff_c", {23'd0, bus.cout, bus.sum}, 32'h1FF);
    do_op(8'h00, 8'h00, 1'b1);
    check("op_00_00_c", {23'd0, bus.cout, bus.sum}, 32'h001);

    // Second start during RUN and operand churn must be ignored.
    @(posedge clk); #1 drive(8'h10, 8'h20, 1'b0, 1'b1);
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 drive(8'hAA, 8'h55, 1'b1, 1'b1);
    @(posedge clk); #1 bus.start = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1 drive(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    end
    check("ignored_start", {23'd0, bus.cout, bus.sum}, 32'h030);

    // Start held high: back-to-back, second operands presented in the DONE cycle.
    @(posedge clk); #1 drive(8'h01, 8'h01, 1'b0, 1'b1);
    @(posedge clk);
    repeat (W) @(posedge clk);
    #1 drive(8'h80, 8'h80, 1'b0, 1'b1);
    @(negedge clk);
    check("b2b_first", {23'd0, bus.cout, bus.sum}, 32'h002);
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (W + 1) @(posedge clk);
    check("b2b_second", {23'd0, bus.cout, bus.sum}, 32'h100);
    repeat (2) @(posedge clk);

    // Asynchronous reset in the middle of a run.
    do_op(8'h35, 8'h4A, 1'b0);
    @(posedge clk); #1 drive(8'h12, 8'h34, 1'b0, 1'b1);
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_busy", {31'd0, bus.busy}, 32'd0);
    check("async_result", {23'd0, bus.cout, bus.sum}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (W + 2) @(posedge clk);
    check("post_rst_hold", {23'd0, bus.cout, bus.sum}, 32'd0);
    do_op(8'h03, 8'h04, 1'b0);
    check("post_rst_op", {23'd0, bus.cout, bus.sum}, 32'h007);

    // Random operations with random gaps, including back-to-back starts.
    for (int n = 0; n < 500; n++) begin
      int gap;
      @(posedge clk); #1 drive(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      gap = W + $urandom_range(0, 3);
      @(posedge clk); #1 drive(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      for (int g = 1; g < gap; g++) begin
        @(posedge clk); #1 drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      end
      #0 bus.start = 1'b0;
    end
    bus.start = 1'b0;
    repeat (W + 4) @(posedge clk);
    check("drain", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_fulladd.md
Name: serial_fulladd

Overview:
- Bit-serial N-bit adder built around a single full-adder cell and a registered carry.
- Performs the inverse operation of the team's full subtractor: a + b + cin, one bit per clock, LSB first.
- Used where area matters more than latency, and as the golden add-side partner when checking subtractor results (a - b recovered by diff + b).
- Start/done handshake; result held until the next operation completes.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk    input   1      rising-edge clock
rst    input   1      reset, asynchronous, active-high
start  input   1      request a new addition; sampled only when not busy
a      input   WIDTH  operand A; captured on the accepted start edge
b      input   WIDTH  operand B; captured on the accepted start edge
cin    input   1      carry-in; captured on the accepted start edge
busy   output  1      high while bits are being processed (RUN state)
done   output  1      single-cycle pulse: sum/cout just became valid
sum    output  WIDTH  registered result (a + b + cin) mod 2^WIDTH
cout   output  1      registered carry-out of bit WIDTH-1

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry and bit counter cleared. Effect is immediate, not clock-gated.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, go to RUN.
  - start=0: remain in IDLE.
- RUN:
  - busy=1.
  - Each edge: s=a_sh[0]^b_sh[0]^carry; carry<=majority(a_sh[0],b_sh[0],carry).
  - Shift a_sh and b_sh right by one; shift s into the result shift register from the MSB end; cnt<=cnt+1.
  - The edge processing bit WIDTH-1 (edge k+WIDTH): sum<=final result, cout<=final carry, go to DONE.
  - start is ignored in RUN; operands are not re-sampled.
- DONE:
  - done=1 and busy=0 for exactly one cycle, so done is visible in the cycle after edge k+WIDTH.
  - start=1 at the next edge is accepted exactly as in IDLE (back-to-back), then go to RUN; otherwise go to IDLE.
- Latency: start accepted at edge k -> sum/cout valid and done=1 after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- Output holding:
  - sum/cout change only on the transition RUN->DONE.
  - They hold the previous result throughout a later RUN, and indefinitely in IDLE.
- Arithmetic:
  - Full WIDTH+1-bit result: {cout,sum} = a + b + cin, unsigned.
  - No overflow flag; wrap-around is modulo 2^WIDTH with carry in cout.
- Operand changes on a/b/cin after the accepted start edge have no effect on the running operation.
- Reset mid-operation: the operation is abandoned, outputs return to 0, and no done pulse occurs. The first start after rst deasserts is accepted normally.
- busy and done are never high simultaneously.
- busy is low in IDLE and DONE.

Test Plan:
1. WIDTH=8; a=0x35, b=0x4A, cin=0, start for one cycle -> busy high for 8 cycles, done pulses one cycle later, sum=0x7F, cout=0.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
3. Start a=0x10, b=0x20; three cycles later pulse start with a=0xAA, b=0x55 and change a/b/cin every cycle -> exactly one done, sum=0x30, cout=0. The second start is ignored.
4. Hold start high continuously with operands 0x01+0x01, then 0x80+0x80 presented on the DONE cycle -> done pulses every 9 cycles; results 0x02/cout0, then 0x00/cout1; no idle cycle between operations.
5. Assert rst asynchronously (mid-cycle) 4 cycles into a RUN after a completed 0x7F result -> sum=0, cout=0, busy=0 immediately, no done pulse. The next start with 0x03+0x04 -> sum=0x07.
6. Randomised: 500 operations with random a, b, cin and random gaps between starts -> every {cout,sum} equals a+b+cin. done is always exactly 8 cycles after the accepted start edge (WIDTH=8), and sum/cout stay stable between done pulses.
